// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default constants for the program counter unit
//
// Purpose : next-PC select encoding and default WIDTH / RAS_DEPTH values,
//           imported by pc_unit and pc_ras.
// Ports   : none (package).
package pc_pkg;

   typedef enum logic [1:0] {
      PC_INC  = 2'b00,
      PC_ADDR = 2'b01,
      PC_BUS  = 2'b10,
      PC_POP  = 2'b11
   } pcmux_t;

   localparam int DEF_WIDTH     = 16;
   localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with sticky overflow/underflow flags
//
// Purpose : top pointer plus count over a circular buffer. A push when full
//           overwrites the oldest entry; a pop when empty leaves the stack alone.
//           Push and pop together replace the top (or push only when empty).
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           push_en, pop_en - qualified push / pop requests (already gated by PC load)
//           push_data       - return address to push
//           flag_clr        - synchronous clear of ovf/unf (set wins)
//           top             - current top-of-stack entry
//           count           - valid entries
//           ovf, unf        - sticky overflow / underflow flags
module pc_ras
   import pc_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int RAS_DEPTH = DEF_RAS_DEPTH
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               push_en,
   input  logic                               pop_en,
   input  logic                               flag_clr,
   input  logic [WIDTH-1:0]                   push_data,
   output logic [WIDTH-1:0]                   top,
   output logic [$clog2(RAS_DEPTH+1)-1:0]     count,
   output logic                               ovf,
   output logic                               unf
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH+1);

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]    top_ptr, ptr_up, ptr_dn, ptr_nx, mem_wa;
   logic [CW-1:0]    cnt_nx;
   logic             empty, full, mem_we, ovf_set, unf_set;

   // Explicit wrap so non-power-of-two depths stay circular.
   assign ptr_up = (top_ptr == PW'(RAS_DEPTH-1)) ? '0 : top_ptr + PW'(1);
   assign ptr_dn = (top_ptr == '0) ? PW'(RAS_DEPTH-1) : top_ptr - PW'(1);
   assign empty  = (count == '0);
   assign full   = (count == CW'(RAS_DEPTH));
   assign top    = mem[top_ptr];

   always_comb begin
      mem_we  = 1'b0;
      mem_wa  = ptr_up;
      ptr_nx  = top_ptr;
      cnt_nx  = count;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (push_en && pop_en && !empty) begin
         // Return through the old top and call again: replace in place.
         mem_we = 1'b0 | 1'b1;
         mem_wa = top_ptr;
      end else if (push_en) begin
         // When full the slot above top is the oldest entry, so writing it overwrites.
         mem_we = 1'b1;
         ptr_nx = ptr_up;
         if (full) ovf_set = 1'b1;
         else      cnt_nx  = count + CW'(1);
         if (pop_en) unf_set = 1'b1;
      end else if (pop_en) begin
         if (empty) begin
            unf_set = 1'b1;
         end else begin
            ptr_nx = ptr_dn;
            cnt_nx = count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_ptr <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         unf     <= 1'b0;
      end else begin
         top_ptr <= ptr_nx;
         count   <= cnt_nx;
         ovf     <= ovf_set | (ovf & ~flag_clr);
         unf     <= unf_set | (unf & ~flag_clr);
      end
   end

   // Storage is not reset; count alone defines validity. Gating on rst drops
   // a push caught by a reset held across the edge.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[mem_wa] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with optional return-address stack
//
// Purpose : registered PC with next-PC select (increment / address adder / bus /
//           stack pop). The return-address stack is compiled in only when the
//           macro PC_UNIT_RAS_EN is defined; otherwise select 11 holds PC.
// Ports   : Clk, Reset     - clock, asynchronous active-high reset
//           LD_PC          - PC load enable (also qualifies push/pop)
//           PCMUX_sig      - next-PC select
//           AddrAdder_out  - address-adder result
//           Bus_out        - datapath bus value
//           push           - call: push PC+1
//           flag_clr       - clear sticky stack flags
//           PC, PC_next    - registered PC, value loaded on next enabled edge
//           ras_count      - valid stack entries
//           ras_ovf/unf    - sticky overflow / underflow flags
module pc_unit
   import pc_pkg::*;
#(
   parameter int          WIDTH     = DEF_WIDTH,
   parameter int          RAS_DEPTH = DEF_RAS_DEPTH,
   parameter int unsigned RESET_VEC = 0
)(
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           LD_PC,
   input  logic [1:0]                     PCMUX_sig,
   input  logic [WIDTH-1:0]               AddrAdder_out,
   input  logic [WIDTH-1:0]               Bus_out,
   input  logic                           push,
   input  logic                           flag_clr,
   output logic [WIDTH-1:0]               PC,
   output logic [WIDTH-1:0]               PC_next,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_ovf,
   output logic                           ras_unf
);

   pcmux_t           sel;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] pop_val;

   assign sel    = pcmux_t'(PCMUX_sig);
   assign pc_inc = PC + WIDTH'(1);   // carry discarded: wraps to zero

`ifdef PC_UNIT_RAS_EN
   logic [WIDTH-1:0] ras_top;
   logic             pop_req;

   assign pop_req = LD_PC && (sel == PC_POP);
   // An empty-stack pop falls through to sequential execution.
   assign pop_val = (ras_count != '0) ? ras_top : pc_inc;

   pc_ras #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (Clk),
      .rst       (Reset),
      .push_en   (LD_PC & push),
      .pop_en    (pop_req),
      .flag_clr  (flag_clr),
      .push_data (pc_inc),
      .top       (ras_top),
      .count     (ras_count),
      .ovf       (ras_ovf),
      .unf       (ras_unf)
   );
`else
   logic unused_ras_inputs;

   assign unused_ras_inputs = ^{push, flag_clr};
   assign pop_val   = PC;
   assign ras_count = '0;
   assign ras_ovf   = 1'b0;
   assign ras_unf   = 1'b0;
`endif

   always_comb begin
      PC_next = pc_inc;
      case (sel)
         PC_INC:  PC_next = pc_inc;
         PC_ADDR: PC_next = AddrAdder_out;
         PC_BUS:  PC_next = Bus_out;
         PC_POP:  PC_next = pop_val;
         default: PC_next = pc_inc;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)      PC <= WIDTH'(RESET_VEC);
      else if (LD_PC) PC <= PC_next;
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, PC/data width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (>=2).
REQ-003 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port LD_PC  input  1  PC load enable; no state changes when 0.
REQ-007 SHALL have port PCMUX_sig  input  2  next-PC select: 00 increment, 01 address adder, 10 bus, 11 stack pop.
REQ-008 SHALL have port AddrAdder_out  input  WIDTH  address-adder result.
REQ-009 SHALL have port Bus_out  input  WIDTH  datapath bus value.
REQ-010 SHALL have port push  input  1  call: push return address PC+1 when LD_PC=1.
REQ-011 SHALL have port flag_clr  input  1  synchronous clear of the sticky flags.
REQ-012 SHALL have port PC  output  WIDTH  registered program counter.
REQ-013 SHALL have port PC_next  output  WIDTH  combinational value PC loads on the next enabled edge.
REQ-014 SHALL have port ras_count  output  $clog2(RAS_DEPTH+1)  valid stack entries.
REQ-015 SHALL have port ras_ovf  output  1  sticky: a push overwrote an entry.
REQ-016 SHALL have port ras_unf  output  1  sticky: a pop hit an empty stack.

Function
REQ-017 PC+1 SHALL wrap modulo 2^WIDTH (all-ones + 1 = 0); carry discarded.
REQ-018 PC_next SHALL be PC+1, AddrAdder_out, Bus_out, or stack top for PCMUX_sig 00/01/10/11.
REQ-019 PC SHALL update to PC_next one cycle after the LD_PC=1 edge; with LD_PC=0, PC holds.
REQ-020 Stack SHALL be a circular buffer: top pointer plus count.
REQ-021 Push with LD_PC=1 and count<RAS_DEPTH SHALL write PC+1 above top and increment count.
REQ-022 Push when full SHALL overwrite the oldest entry, keep count=RAS_DEPTH and set ras_ovf.
REQ-023 Pop (LD_PC=1, PCMUX_sig=11) with count>0 SHALL load PC from top and decrement count.
REQ-024 Pop with count=0 SHALL load PC+1 instead, leave the stack unchanged and set ras_unf.
REQ-025 Simultaneous push and pop SHALL load PC from the old top, replace top with PC+1 and keep count unchanged; with count=0 it SHALL push only, set ras_unf, and load PC+1.
REQ-026 push and pop SHALL be ignored when LD_PC=0.
REQ-027 flag_clr SHALL clear ras_ovf/ras_unf; a same-cycle set event SHALL take priority over the clear.

Reset
REQ-028 Reset SHALL immediately set PC=RESET_VEC, ras_count=0, ras_ovf=0, ras_unf=0, independent of Clk.
REQ-029 Reset asserted mid-sequence SHALL discard any in-flight push/pop; stack contents need not be cleared, only count.
REQ-030 After Reset deasserts, the first enabled edge SHALL behave as from the reset state.

Configuration
REQ-031 Macro PC_UNIT_RAS_EN defined SHALL compile in the return-address stack per REQ-020..027.
REQ-032 Without PC_UNIT_RAS_EN, PCMUX_sig=11 SHALL hold PC (PC_next=PC); push and flag_clr are ignored; ras_count, ras_ovf, ras_unf SHALL be constant 0; no stack storage is inferred.

Structure
REQ-033 Shared package pc_pkg SHALL hold the pcmux_t enum (PC_INC, PC_ADDR, PC_BUS, PC_POP) and default WIDTH/RAS_DEPTH constants.
REQ-034 The stack SHALL be sub-module pc_ras (parameters WIDTH, RAS_DEPTH), instantiated only under PC_UNIT_RAS_EN.

Verification
REQ-035 Reset, LD_PC=1, PCMUX 00 for 3 cycles from RESET_VEC=0x0000 -> PC 0x0001, 0x0002, 0x0003; PC=0xFFFF + inc -> 0x0000.
REQ-036 PC=0x3000, push with PCMUX 01, AddrAdder_out=0x4000 -> PC=0x4000, count=1; then PCMUX 11 -> PC=0x3001, count=0.
REQ-037 Five pushes at PC 0x10,0x20,0x30,0x40,0x50 (DEPTH 4) -> ras_ovf=1, count=4; four pops return 0x51,0x41,0x31,0x21.
REQ-038 Pop with count=0 at PC=0x0100 -> PC=0x0101, ras_unf=1; flag_clr -> ras_unf=0 next cycle.
REQ-039 Push+pop together with top=0x2000, PC=0x5000 -> PC=0x2000, top=0x5001, count unchanged; LD_PC=0 with push -> no change.
REQ-040 Reset asserted mid-cycle between edges -> PC=RESET_VEC and count=0 before the next Clk edge; build without PC_UNIT_RAS_EN -> PCMUX 11 holds PC.
